// File: rtl/hx8357_init_seq.sv
// Power-on sequencer for the HX8357 controller: plays the init script, then
// clears the panel with a CASET/PASET/RAMWR fill, with a handshake watchdog.
module hx8357_init_seq #(
    parameter int DELAY_UNIT_CYCLES = 25000,
    parameter int H_RES             = 320,
    parameter int V_RES             = 480,
    parameter int WDOG_CYCLES       = 65535
) (
    input  logic        clk,
    input  logic        nres,
    input  logic        start,
    input  logic [15:0] fill_color,
    output logic        busy,
    output logic        init_done,
    output logic        error,
    output logic        ctl_cmd,
    output logic        ctl_data,
    output logic [15:0] ctl_data_in,
    input  logic        supply_data,
    input  logic        transmission_cmpl
);

    typedef enum logic [3:0] {
        IDLE, FETCH, CMD_REQ, CMD_WAIT, DAT_REQ, DAT_WAIT, DELAY, FILL_SETUP, DONE, ERROR
    } state_t;

    localparam logic [1:0]  TY_CMD    = 2'b00;
    localparam logic [1:0]  TY_PARAM  = 2'b01;
    localparam logic [1:0]  TY_DELAY  = 2'b10;
    localparam logic [1:0]  TY_END    = 2'b11;
    localparam logic [3:0]  ROM_END   = 4'd10;
    localparam logic [3:0]  PIX_IDX   = 4'd11;
    localparam logic [15:0] H_LAST    = 16'(H_RES - 1);
    localparam logic [15:0] V_LAST    = 16'(V_RES - 1);
    localparam logic [23:0] PIX_TOTAL = 24'(H_RES * V_RES);
    localparam logic [31:0] WDOG_LOAD = 32'(WDOG_CYCLES);
    localparam logic [31:0] UNIT      = 32'(DELAY_UNIT_CYCLES);

    state_t      state;
    logic [3:0]  ptr;
    logic        fill_mode;
    logic [23:0] pix_cnt;
    logic [31:0] dly_cnt;
    logic [31:0] wd_cnt;
    logic [15:0] fill_col;
    logic        sd_r;
    logic        tc_r;
    logic        sd_ev;
    logic        tc_ev;
    logic [3:0]  nxt_ptr;
    logic [23:0] nxt_pix;
    logic [17:0] cur;
    logic [17:0] nxt;

    // In fill mode the entry list is synthesised; index 11 repeats for every pixel.
    function automatic logic [17:0] entry_at(input logic fill, input logic [3:0] idx,
                                             input logic [23:0] pix, input logic [15:0] color);
        logic [17:0] e;
        if (!fill) begin
            case (idx)
                4'd0:    e = {TY_CMD,   16'h0001};
                4'd1:    e = {TY_DELAY, 16'd10};
                4'd2:    e = {TY_CMD,   16'h0011};
                4'd3:    e = {TY_DELAY, 16'd120};
                4'd4:    e = {TY_CMD,   16'h003A};
                4'd5:    e = {TY_PARAM, 16'h0055};
                4'd6:    e = {TY_CMD,   16'h0036};
                4'd7:    e = {TY_PARAM, 16'h0000};
                4'd8:    e = {TY_CMD,   16'h0029};
                4'd9:    e = {TY_DELAY, 16'd10};
                default: e = {TY_END,   16'h0000};
            endcase
        end else begin
            case (idx)
                4'd0:    e = {TY_CMD,   16'h002A};
                4'd1:    e = {TY_PARAM, 16'h0000};
                4'd2:    e = {TY_PARAM, 16'h0000};
                4'd3:    e = {TY_PARAM, 8'h00, H_LAST[15:8]};
                4'd4:    e = {TY_PARAM, 8'h00, H_LAST[7:0]};
                4'd5:    e = {TY_CMD,   16'h002B};
                4'd6:    e = {TY_PARAM, 16'h0000};
                4'd7:    e = {TY_PARAM, 16'h0000};
                4'd8:    e = {TY_PARAM, 8'h00, V_LAST[15:8]};
                4'd9:    e = {TY_PARAM, 8'h00, V_LAST[7:0]};
                4'd10:   e = {TY_CMD,   16'h002C};
                PIX_IDX: e = (pix != 24'd0) ? {TY_PARAM, color} : {TY_END, 16'h0000};
                default: e = {TY_END,   16'h0000};
            endcase
        end
        return e;
    endfunction

    assign sd_ev = supply_data & ~sd_r;
    assign tc_ev = transmission_cmpl & ~tc_r;

    always_comb begin
        if (fill_mode && ptr == PIX_IDX) begin
            nxt_ptr = ptr;
            nxt_pix = pix_cnt - 24'd1;
        end else begin
            nxt_ptr = ptr + 4'd1;
            nxt_pix = pix_cnt;
        end
    end

    assign cur = entry_at(fill_mode, ptr, pix_cnt, fill_col);
    assign nxt = entry_at(fill_mode, nxt_ptr, nxt_pix, fill_col);

    always_ff @(posedge clk or negedge nres) begin
        if (!nres) begin
            state       <= IDLE;
            ptr         <= 4'd0;
            fill_mode   <= 1'b0;
            pix_cnt     <= 24'd0;
            dly_cnt     <= 32'd0;
            wd_cnt      <= 32'd0;
            fill_col    <= 16'h0000;
            sd_r        <= 1'b0;
            tc_r        <= 1'b0;
            busy        <= 1'b0;
            init_done   <= 1'b0;
            error       <= 1'b0;
            ctl_cmd     <= 1'b0;
            ctl_data    <= 1'b0;
            ctl_data_in <= 16'h0000;
        end else begin
            sd_r <= supply_data;
            tc_r <= transmission_cmpl;
            // Free-running outside handshakes; only inspected in REQ/WAIT states.
            if (sd_ev || tc_ev) begin
                wd_cnt <= WDOG_LOAD;
            end else if (wd_cnt != 32'd0) begin
                wd_cnt <= wd_cnt - 32'd1;
            end

            case (state)
                IDLE, DONE, ERROR: begin
                    if (start) begin
                        busy      <= 1'b1;
                        error     <= 1'b0;
                        init_done <= 1'b0;
                        fill_col  <= fill_color;
                        fill_mode <= 1'b0;
                        ptr       <= (state == DONE) ? ROM_END : 4'd0;
                        state     <= FETCH;
                    end
                end
                FETCH: begin
                    wd_cnt <= WDOG_LOAD;
                    case (cur[17:16])
                        TY_CMD: begin
                            ctl_cmd <= 1'b1;
                            state   <= CMD_REQ;
                        end
                        TY_PARAM: begin
                            ctl_data <= 1'b1;
                            state    <= DAT_REQ;
                        end
                        TY_DELAY: begin
                            if (cur[15:0] == 16'd0) begin
                                ptr <= nxt_ptr;
                            end else begin
                                dly_cnt <= {16'd0, cur[15:0]} * UNIT;
                                state   <= DELAY;
                            end
                        end
                        default: begin
                            if (fill_mode) begin
                                busy      <= 1'b0;
                                init_done <= 1'b1;
                                state     <= DONE;
                            end else begin
                                state <= FILL_SETUP;
                            end
                        end
                    endcase
                end
                FILL_SETUP: begin
                    fill_mode <= 1'b1;
                    ptr       <= 4'd0;
                    pix_cnt   <= PIX_TOTAL;
                    state     <= FETCH;
                end
                DELAY: begin
                    if (dly_cnt <= 32'd1) begin
                        ptr   <= nxt_ptr;
                        state <= FETCH;
                    end else begin
                        dly_cnt <= dly_cnt - 32'd1;
                    end
                end
                CMD_REQ: begin
                    if (sd_ev) begin
                        ctl_data_in <= cur[15:0];
                        ctl_cmd     <= 1'b0;
                        state       <= CMD_WAIT;
                    end else if (wd_cnt == 32'd0) begin
                        ctl_cmd  <= 1'b0;
                        ctl_data <= 1'b0;
                        error    <= 1'b1;
                        busy     <= 1'b0;
                        state    <= ERROR;
                    end
                end
                CMD_WAIT: begin
                    if (tc_ev) begin
                        ptr     <= nxt_ptr;
                        pix_cnt <= nxt_pix;
                        state   <= FETCH;
                    end else if (wd_cnt == 32'd0) begin
                        ctl_cmd  <= 1'b0;
                        ctl_data <= 1'b0;
                        error    <= 1'b1;
                        busy     <= 1'b0;
                        state    <= ERROR;
                    end
                end
                DAT_REQ: begin
                    if (sd_ev) begin
                        ctl_data_in <= cur[15:0];
                        state       <= DAT_WAIT;
                    end else if (wd_cnt == 32'd0) begin
                        ctl_cmd  <= 1'b0;
                        ctl_data <= 1'b0;
                        error    <= 1'b1;
                        busy     <= 1'b0;
                        state    <= ERROR;
                    end
                end
                DAT_WAIT: begin
                    if (tc_ev) begin
                        ptr     <= nxt_ptr;
                        pix_cnt <= nxt_pix;
                        // Keep the burst open while the next entry is another data word.
                        if (nxt[17:16] == TY_PARAM) begin
                            if (sd_ev) begin
                                ctl_data_in <= nxt[15:0];
                                state       <= DAT_WAIT;
                            end else begin
                                state <= DAT_REQ;
                            end
                        end else begin
                            ctl_data <= 1'b0;
                            state    <= FETCH;
                        end
                    end else if (wd_cnt == 32'd0) begin
                        ctl_cmd  <= 1'b0;
                        ctl_data <= 1'b0;
                        error    <= 1'b1;
                        busy     <= 1'b0;
                        state    <= ERROR;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/hx8357_init_seq.md
# hx8357_init_seq

Power-on sequencer for the HX8357 display path. It sits directly upstream of `HX8357_controller` and drives that block's `cmd`/`data`/`data_in` request interface. It plays a fixed initialization script of commands, parameters and millisecond delays, then clears the full panel to a programmable colour with a CASET/PASET/RAMWR burst. It guards every controller handshake with a watchdog.

## Interface
- `DELAY_UNIT_CYCLES`, default 25000: clock cycles per script delay unit (1 ms at 25 MHz).
- `H_RES`, default 320: panel columns; the fill width.
- `V_RES`, default 480: panel rows; the fill height.
- `WDOG_CYCLES`, default 65535: maximum number of cycles to wait for any single controller handshake event.
- `clk` in 1: system clock; all state updates on the rising edge.
- `nres` in 1: asynchronous, active-low reset.
- `start` in 1: single-cycle pulse that launches a sequence.
- `fill_color` in 16: RGB565 fill value, sampled in the cycle `start` is accepted.
- `busy` out 1: high while a sequence is running.
- `init_done` out 1: high once the script and the fill complete without error.
- `error` out 1: sticky watchdog failure flag.
- `ctl_cmd` out 1: command request to the controller (its `cmd` port).
- `ctl_data` out 1: data-burst request to the controller (its `data` port).
- `ctl_data_in` out 16: word presented to the controller (its `data_in` port).
- `supply_data` in 1: controller requests the next word.
- `transmission_cmpl` in 1: controller has finished the current word.

## Operation
- Script ROM is internal. Each 18-bit entry is {type[1:0], value[15:0]}. Types: 00 = CMD, 01 = PARAM, 10 = DELAY (value in ms), 11 = END.
- Fixed script content:
  - CMD 0x01, DELAY 10
  - CMD 0x11, DELAY 120
  - CMD 0x3A, PARAM 0x0055
  - CMD 0x36, PARAM 0x0000
  - CMD 0x29, DELAY 10
  - END
- Fill phase, generated from counters and not stored in the ROM:
  - CMD 0x2A with params 0x0000, 0x0000, (H_RES-1)>>8, (H_RES-1)&0xFF
  - CMD 0x2B with params 0x0000, 0x0000, (V_RES-1)>>8, (V_RES-1)&0xFF
  - CMD 0x2C followed by H_RES*V_RES words of `fill_color`
- Pixel counter is 24 bits wide and counts down to zero; no wrap is possible.
- States: IDLE, FETCH, CMD_REQ, CMD_WAIT, DAT_REQ, DAT_WAIT, DELAY, FILL_SETUP, DONE, ERROR.
- IDLE, DONE or ERROR + `start` → FETCH.
  - From IDLE or ERROR: ROM pointer = 0 and the full script runs.
  - From DONE: the script is skipped and only the fill phase runs.
- FETCH branches on the entry type:
  - CMD → CMD_REQ.
  - PARAM → DAT_REQ.
  - DELAY → DELAY; a value of 0 skips straight to FETCH of the next entry.
  - END → FILL_SETUP.
- CMD_REQ:
  - `ctl_cmd`=1 is held until the rising edge of `supply_data`.
  - On that edge, in the same cycle: `ctl_data_in`=opcode, `ctl_cmd`=0, go to CMD_WAIT.
- CMD_WAIT: on the rising edge of `transmission_cmpl`, advance the pointer and go to FETCH.
- DAT_REQ / DAT_WAIT: `ctl_data`=1 stays asserted across every consecutive PARAM entry, and across the whole pixel stream.
  - Each `supply_data` rising edge loads the next word.
  - `ctl_data` drops in the cycle after the last word's `transmission_cmpl` rising edge.
- DELAY: a down-counter is loaded with value*DELAY_UNIT_CYCLES (32 bits wide); the FSM returns to FETCH when the counter reaches 0.
- DONE: `init_done`=1, `busy`=0.
- `start` while `busy` is ignored.

## Timing
- Reset values: `busy`, `init_done`, `error`, `ctl_cmd` and `ctl_data` = 0; `ctl_data_in` = 0x0000; state = IDLE.
- Asserting `nres` at any point aborts all activity immediately (asynchronously). No partial burst is resumed.
- Edge detection: `supply_data` and `transmission_cmpl` are registered once. An event is current=1 and previous=0. A level held high across several cycles counts as one event.
- `start` to `ctl_cmd`=1 takes 2 cycles: accept, then FETCH.
- A supply and a completion edge arriving in the same cycle are both processed: the word is loaded and the completion is counted.
- Watchdog:
  - The counter reloads on entry to every REQ/WAIT state and on every handshake event.
  - Expiry → ERROR with `ctl_cmd`=0, `ctl_data`=0, `error`=1 and `busy`=0.
  - `error` clears on the next accepted `start`.
  - The watchdog is disabled in DELAY.
- `init_done` clears on an accepted `start`.

## Test plan
- Reset/idle: hold `nres`=0 for 5 cycles, release → all outputs 0; no `ctl_cmd` within 100 cycles without `start`.
- Full script, behavioural controller model, DELAY_UNIT_CYCLES=4, H_RES=4, V_RES=2:
  - Opcodes must arrive in order 01,11,3A,36,29,2A,2B,2C.
  - Params must be 55 | 00 | 00,00,00,03 | 00,00,00,01.
  - The fill must be exactly 8 words of `fill_color`=0xF800.
  - `init_done`=1 at the end.
- Delay accuracy, same parameters: the cycle count from `transmission_cmpl` of 0x11 to `ctl_cmd` for 0x3A is 480±3.
- Burst framing: `ctl_data` stays high continuously through the 4 CASET params and drops exactly 1 cycle after the 4th `transmission_cmpl` edge.
- Watchdog: WDOG_CYCLES=16 and the model never raises `supply_data` after opcode 0x11 → `error`=1 and `ctl_cmd`=0 within 18 cycles; a following `start` clears `error` and reruns from 0x01.
- Re-fill and abort:
  - `start` in DONE with `fill_color`=0x001F → opcodes 2A,2B,2C only, then 8 words of 0x001F.
  - `nres` pulsed mid-fill → outputs return to reset values asynchronously.
